fb_combiner: RTL
================

FB_COMBINER -- requirements
Module: fb_combiner

Interface
REQ-001 Parameters SHALL be:
- NCH, default 4: number of gain-scaled channels; legal 1..8.
- IN_W, default 15: signed width of each channel input.
- OUT_W, default 13: signed width of the DAC word.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock; one clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- store_strb  in  1  feedback window; high = window open.
- fb_cond  in  1  one-cycle sample-valid pulse for ch_in.
- ch_in  in  NCH*IN_W  packed signed channel products; channel k at bits [k*IN_W +: IN_W].
- ch_en_b  in  NCH  per-channel enable; slow domain.
- offset_b  in  OUT_W  signed static correction; slow domain.
- const_dac_b  in  OUT_W  constant/ramp start word; slow domain.
- mode_b  in  2  output mode: 0 feedback, 1 constant, 2 ramp, 3 reserved; slow domain.
- fb_en_b  in  1  feedback enable; slow domain.
- sat_en_b  in  1  1 = saturate on overflow, 0 = wrap; slow domain.
- oflow_clr  in  1  clears sticky oflow.
- fb_sgnl  out  OUT_W  registered DAC word.
- dac_strb  out  1  one-cycle pulse, coincident with each fb_sgnl update.
- oflow  out  1  sticky overflow flag.
- upd_cnt  out  16  count of updates in the current window.
- active  out  1  high while in ACTIVE.

Function
REQ-003 All *_b inputs SHALL pass through a two-flop synchroniser before use; synchroniser flops are excluded from shift-register extraction.
REQ-004 The FSM SHALL have two states:
- IDLE to ACTIVE on the first cycle store_strb is high.
- ACTIVE to IDLE on the first cycle store_strb is low.
REQ-005 On IDLE-to-ACTIVE entry, the block SHALL latch the synchronised mode, and upd_cnt SHALL clear to 0.
REQ-006 In IDLE: fb_sgnl SHALL be 0, no dac_strb SHALL issue, and in-flight pipeline data SHALL be discarded.
REQ-007 The pipeline SHALL be three stages:
- S1: register fb_cond and each ch_in word, with disabled channels forced to 0.
- S2: register the full-width sum of all channels plus the sign-extended offset.
- S3: mode select, saturate/wrap, drive fb_sgnl and dac_strb.
REQ-008 Latency SHALL be exactly 3 cycles: fb_cond at cycle T gives dac_strb and a new fb_sgnl at T+3, provided the block is ACTIVE at T+3.
REQ-009 The internal sum width SHALL be IN_W + ceil(log2(NCH)) + 1 bits, so the sum never overflows internally.
REQ-010 Overflow SHALL be detected when the S2 sum lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], in mode 0 only.
REQ-011 On overflow: if sat_en, fb_sgnl SHALL clamp to the max or min value; else fb_sgnl SHALL take the low OUT_W bits.
REQ-012 oflow SHALL set on any overflow and hold until an oflow_clr cycle; when set and clear coincide, set wins.
REQ-013 Mode 0: each update SHALL output the S3 result when fb_en is 1, and 0 when fb_en is 0; dac_strb is still issued.
REQ-014 Mode 1: each update SHALL output const_dac.
REQ-015 Mode 2, ramp:
- first update in the window outputs const_dac;
- each later update outputs the previous value + 1;
- wraps two's-complement at the OUT_W limit, with no oflow.
REQ-016 Mode 3: each update SHALL output 0, and dac_strb SHALL still pulse.
REQ-017 Between updates, fb_sgnl SHALL hold its last value.
REQ-018 upd_cnt SHALL increment on each dac_strb and saturate at 0xFFFF.
REQ-019 Configuration changes mid-window SHALL take effect 2 cycles after the input changes, except mode, which changes only at the next window entry.
REQ-020 fb_cond pulses while IDLE SHALL produce no dac_strb.
REQ-021 If the window closes with updates in flight, those updates SHALL be dropped.

Reset
REQ-022 While rst is high, the block SHALL hold:
- FSM in IDLE;
- fb_sgnl, dac_strb, oflow, upd_cnt, active all 0;
- pipeline valid bits and synchroniser flops 0.
REQ-023 Reset asserted mid-window SHALL take priority over store_strb; the block returns to ACTIVE only on a fresh store_strb high after rst deasserts.

Verification
REQ-024 NCH=4, mode 0, all channels enabled, inputs 100/200/-50/10, offset 5, one fb_cond -> fb_sgnl=265 and dac_strb exactly 3 cycles later, upd_cnt=1.
REQ-025 Inputs 4000 x4, sat_en=1 -> fb_sgnl=4095 and oflow=1; repeat with sat_en=0 -> fb_sgnl = low 13 bits of 16000 (-384); oflow_clr -> oflow=0.
REQ-026 ch_en_b=4'b0101 with inputs 1/2/4/8 -> fb_sgnl=5; fb_en_b=0 -> fb_sgnl=0 with dac_strb still pulsing.
REQ-027 Mode 2, const_dac=4094, 4 fb_cond pulses -> outputs 4094, 4095, -4096, -4095; oflow stays 0.
REQ-028 store_strb drops 1 cycle after fb_cond -> no dac_strb and fb_sgnl=0; mode_b changed mid-window -> no effect until the next window.
REQ-029 rst pulsed mid-window with updates in flight -> all outputs 0 the following cycle, and no dac_strb until a new window plus 3 cycles.

Source files
------------

// File: rtl/fb_combiner_if.sv
// Handshake and configuration bundle between a feedback source and fb_combiner.
// Latency: none (wires only).
// Backpressure: none; fb_cond and dac_strb are single-cycle strobes.
interface fb_combiner_if #(
    parameter int NCH   = 4,
    parameter int IN_W  = 15,
    parameter int OUT_W = 13
);
    logic                  store_strb;
    logic                  fb_cond;
    logic [NCH*IN_W-1:0]   ch_in;
    logic [NCH-1:0]        ch_en_b;
    logic [OUT_W-1:0]      offset_b;
    logic [OUT_W-1:0]      const_dac_b;
    logic [1:0]            mode_b;
    logic                  fb_en_b;
    logic                  sat_en_b;
    logic                  oflow_clr;
    logic [OUT_W-1:0]      fb_sgnl;
    logic                  dac_strb;
    logic                  oflow;
    logic [15:0]           upd_cnt;
    logic                  active;

    // Stimulus side: drives window, samples and configuration.
    modport master (
        output store_strb, fb_cond, ch_in, ch_en_b, offset_b, const_dac_b,
               mode_b, fb_en_b, sat_en_b, oflow_clr,
        input  fb_sgnl, dac_strb, oflow, upd_cnt, active
    );

    // Combiner side.
    modport slave (
        input  store_strb, fb_cond, ch_in, ch_en_b, offset_b, const_dac_b,
               mode_b, fb_en_b, sat_en_b, oflow_clr,
        output fb_sgnl, dac_strb, oflow, upd_cnt, active
    );
endinterface

// File: rtl/fb_combiner.sv
// Sums gain-scaled channels plus offset into a DAC word with const/ramp modes.
// Latency: fb_cond to dac_strb/fb_sgnl is 3 cycles while the window stays open.
// Backpressure: none; updates in flight when the window closes are dropped.
module fb_combiner #(
    parameter int NCH   = 4,
    parameter int IN_W  = 15,
    parameter int OUT_W = 13
) (
    input  logic         clk,
    input  logic         rst,
    fb_combiner_if.slave bus
);
    localparam int SUM_W = IN_W + $clog2(NCH) + 1;
    localparam int CFG_W = NCH + 2 * OUT_W + 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Slow-domain configuration, retimed through two flops before any use.
    (* shreg_extract = "no" *) logic [CFG_W-1:0] sync1_q;
    (* shreg_extract = "no" *) logic [CFG_W-1:0] sync2_q;

    logic [NCH-1:0]   ch_en_s;
    logic [OUT_W-1:0] offset_s;
    logic [OUT_W-1:0] const_s;
    logic [1:0]       mode_s;
    logic             fb_en_s;
    logic             sat_en_s;

    assign {ch_en_s, offset_s, const_s, mode_s, fb_en_s, sat_en_s} = sync2_q;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic                      v1_q, v1_d;
    logic                      v2_q, v2_d;
    logic [NCH-1:0][IN_W-1:0]  s1_ch_q, s1_ch_d;
    logic [SUM_W-1:0]          s2_sum_q, s2_sum_d;
    logic [OUT_W-1:0]          fb_q, fb_d;
    logic                      strb_q, strb_d;
    logic                      oflow_q, oflow_d;
    logic                      first_q, first_d;
    logic [15:0]               cnt_q, cnt_d;

    logic                      entry;
    logic                      run;
    logic                      upd;
    logic [SUM_W-1:0]          acc;
    logic [SUM_W-OUT_W:0]      sum_hi;
    logic                      ovf_raw;
    logic [OUT_W-1:0]          sat_val;
    logic [OUT_W-1:0]          fb_val;
    logic [OUT_W-1:0]          new_val;

    // Window FSM: open while store_strb is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.store_strb)  state_d = ACTIVE;
            ACTIVE:  if (!bus.store_strb) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pipeline, output select and status next-state.
    always_comb begin
        entry = (state_q == IDLE) && (state_d == ACTIVE);
        run   = (state_q == ACTIVE);
        // An update is only issued if the window is still open when it lands.
        upd   = v2_q && run && (state_d == ACTIVE);

        // S1: capture samples; valid bits die whenever the window is shut.
        v1_d = bus.fb_cond && run;
        for (int k = 0; k < NCH; k++) begin
            s1_ch_d[k] = ch_en_s[k] ? bus.ch_in[k*IN_W +: IN_W] : '0;
        end

        // S2: full-width sum, wide enough that it cannot overflow itself.
        v2_d = v1_q && run;
        acc  = {{(SUM_W-OUT_W){offset_s[OUT_W-1]}}, offset_s};
        for (int k = 0; k < NCH; k++) begin
            acc = acc + {{(SUM_W-IN_W){s1_ch_q[k][IN_W-1]}}, s1_ch_q[k]};
        end
        s2_sum_d = acc;

        // S3: the sum fits OUT_W iff all bits from the OUT_W sign bit up agree.
        sum_hi  = s2_sum_q[SUM_W-1:OUT_W-1];
        ovf_raw = !((&sum_hi) || !(|sum_hi));
        sat_val = s2_sum_q[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        fb_val  = (ovf_raw && sat_en_s) ? sat_val : s2_sum_q[OUT_W-1:0];

        case (mode_q)
            2'd0:    new_val = fb_en_s ? fb_val : '0;
            2'd1:    new_val = const_s;
            2'd2:    new_val = first_q ? const_s : fb_q + OUT_W'(1);
            default: new_val = '0;
        endcase

        fb_d = fb_q;
        if (state_d != ACTIVE) begin
            fb_d = '0;
        end else if (upd) begin
            fb_d = new_val;
        end

        strb_d  = upd;
        oflow_d = (oflow_q && !bus.oflow_clr) || (upd && (mode_q == 2'd0) && ovf_raw);

        cnt_d = cnt_q;
        if (entry) begin
            cnt_d = '0;
        end else if (upd && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        mode_d = entry ? mode_s : mode_q;

        first_d = first_q;
        if (entry) begin
            first_d = 1'b1;
        end else if (upd) begin
            first_d = 1'b0;
        end
    end

    // Configuration synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.ch_en_b, bus.offset_b, bus.const_dac_b,
                        bus.mode_b, bus.fb_en_b, bus.sat_en_b};
            sync2_q <= sync1_q;
        end
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            s1_ch_q  <= '0;
            s2_sum_q <= '0;
            fb_q     <= '0;
            strb_q   <= 1'b0;
            oflow_q  <= 1'b0;
            first_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            s1_ch_q  <= s1_ch_d;
            s2_sum_q <= s2_sum_d;
            fb_q     <= fb_d;
            strb_q   <= strb_d;
            oflow_q  <= oflow_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.fb_sgnl  = fb_q;
    assign bus.dac_strb = strb_q;
    assign bus.oflow    = oflow_q;
    assign bus.upd_cnt  = cnt_q;
    assign bus.active   = (state_q == ACTIVE);
endmodule
